// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the single register-file write port between the
// ALU and load paths: MEM-first priority with a bounded streak so ALU is never starved.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int MAX_STREAK = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Hold,
    input  logic              ALU_Valid,
    output logic              ALU_Ready,
    input  logic [ADDR_W-1:0] ALU_Add,
    input  logic [DATA_W-1:0] ALU_Data,
    input  logic              MEM_Valid,
    output logic              MEM_Ready,
    input  logic [ADDR_W-1:0] MEM_Add,
    input  logic [DATA_W-1:0] MEM_Data,
    output logic [ADDR_W-1:0] Add_Dest,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Write_En,
    output logic              Wb_Src
);

    typedef enum logic {PRIO_MEM, PRIO_ALU} state_t;

    localparam logic [3:0] STREAK_LAST = 4'(MAX_STREAK - 1);

    state_t            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic [ADDR_W-1:0] add_dest_q, add_dest_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              write_en_q, write_en_d;
    logic              wb_src_q, wb_src_d;
    logic              grant_ok, grant_mem, grant_alu;

    always_comb begin
        grant_ok  = !RST && !Hold;
        grant_mem = grant_ok && MEM_Valid && (state_q == PRIO_MEM || !ALU_Valid);
        grant_alu = grant_ok && ALU_Valid && (state_q == PRIO_ALU || !MEM_Valid);

        state_d      = state_q;
        streak_d     = streak_q;
        add_dest_d   = add_dest_q;
        write_data_d = write_data_q;
        wb_src_d     = wb_src_q;
        write_en_d   = 1'b0;

        if (grant_mem) begin
            add_dest_d   = MEM_Add;
            write_data_d = MEM_Data;
            wb_src_d     = 1'b1;
            write_en_d   = (MEM_Add != '0);
        end else if (grant_alu) begin
            add_dest_d   = ALU_Add;
            write_data_d = ALU_Data;
            wb_src_d     = 1'b0;
            write_en_d   = (ALU_Add != '0);
        end

        // Hold freezes priority state; otherwise count MEM wins over a waiting ALU.
        if (grant_ok) begin
            if (grant_mem && ALU_Valid) begin
                if (streak_q == STREAK_LAST) begin
                    state_d  = PRIO_ALU;
                    streak_d = '0;
                end else begin
                    streak_d = streak_q + 4'd1;
                end
            end else if (grant_alu || !ALU_Valid) begin
                streak_d = '0;
                state_d  = PRIO_MEM;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= PRIO_MEM;
            streak_q     <= '0;
            add_dest_q   <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
            wb_src_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            add_dest_q   <= add_dest_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            wb_src_q     <= wb_src_d;
        end
    end

    assign ALU_Ready  = grant_alu;
    assign MEM_Ready  = grant_mem;
    assign Add_Dest   = add_dest_q;
    assign Write_Data = write_data_q;
    assign Write_En   = write_en_q;
    assign Wb_Src     = wb_src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised + directed bench for regfile_wb_arbiter: a per-cycle reference
// model pushes expected register-file writes into a queue that a monitor drains.
module tb_regfile_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int MAX_STREAK = 4;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] data;
        logic              src;
    } wb_t;

    logic              clk = 1'b0;
    logic              rst, hold;
    logic              alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0] alu_add, mem_add, add_dest;
    logic [DATA_W-1:0] alu_data, mem_data, write_data;
    logic              write_en, wb_src;

    int tests = 0;
    int fails = 0;
    wb_t exp_q[$];

    // reference model: count of MEM wins since ALU was last served or idle
    int  mem_wins = 0;
    wb_t m_out = '{we: 1'b0, add: '0, data: '0, src: 1'b0};

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_STREAK(MAX_STREAK)) dut (
        .CLK(clk), .RST(rst), .Hold(hold),
        .ALU_Valid(alu_valid), .ALU_Ready(alu_ready), .ALU_Add(alu_add), .ALU_Data(alu_data),
        .MEM_Valid(mem_valid), .MEM_Ready(mem_ready), .MEM_Add(mem_add), .MEM_Data(mem_data),
        .Add_Dest(add_dest), .Write_Data(write_data), .Write_En(write_en), .Wb_Src(wb_src)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic h,
                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       output logic ga, output logic gm);
        logic ok, alu_first;
        @(negedge clk);
        rst = r; hold = h;
        alu_valid = av; alu_add = aa; alu_data = ad;
        mem_valid = mv; mem_add = ma; mem_data = md;
        #1;
        ok        = !r && !h;
        alu_first = (mem_wins >= MAX_STREAK);
        gm = ok && mv && (!alu_first || !av);
        ga = ok && av && (alu_first || !mv);
        tests++;
        if (alu_ready !== ga || mem_ready !== gm) begin
            fails++;
            $display("FAIL ready: got alu=%b mem=%b, want alu=%b mem=%b (t=%0t)",
                     alu_ready, mem_ready, ga, gm, $time);
        end
        if (r) begin
            mem_wins = 0;
            m_out = '{we: 1'b0, add: '0, data: '0, src: 1'b0};
        end else if (h) begin
            m_out.we = 1'b0;
        end else if (gm) begin
            m_out = '{we: (ma != 0), add: ma, data: md, src: 1'b1};
            mem_wins = av ? mem_wins + 1 : 0;
        end else if (ga) begin
            m_out = '{we: (aa != 0), add: aa, data: ad, src: 1'b0};
            mem_wins = 0;
        end else begin
            m_out.we = 1'b0;
            if (!av) mem_wins = 0;
        end
        exp_q.push_back(m_out);
    endtask

    // monitor: registered outputs are presented every cycle after the edge
    initial begin
        wb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (write_en !== e.we || add_dest !== e.add || write_data !== e.data || wb_src !== e.src) begin
                    fails++;
                    $display("FAIL wb: got we=%b add=%0d data=%0d src=%b, want we=%b add=%0d data=%0d src=%b (t=%0t)",
                             write_en, add_dest, write_data, wb_src, e.we, e.add, e.data, e.src, $time);
                end
            end
        end
    end

    initial begin
        logic ga, gm;
        logic pa, pm;
        logic [ADDR_W-1:0] ra, rm;
        logic [DATA_W-1:0] rda, rdm;
        rst = 1'b1; hold = 1'b0;
        alu_valid = 1'b0; alu_add = '0; alu_data = '0;
        mem_valid = 1'b0; mem_add = '0; mem_data = '0;

        // reset with both requesters pending
        repeat (2) cyc(1, 0, 1, 5'd9, 32'd99, 1, 5'd8, 32'd88, ga, gm);
        // ALU alone
        cyc(0, 0, 1, 5'd1, 32'd20, 0, 5'd0, 32'd0, ga, gm);
        cyc(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ga, gm);
        // simultaneous: MEM first, then ALU
        cyc(0, 0, 1, 5'd3, 32'd5, 1, 5'd2, 32'd25, ga, gm);
        cyc(0, 0, 1, 5'd3, 32'd5, 0, 5'd0, 32'd0, ga, gm);
        cyc(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ga, gm);
        // streak: MEM continuous, ALU(7,4) held until served
        pa = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, pa, 5'd7, 32'd4, 1, 5'(i + 1), 32'((i + 1) * 10), ga, gm);
            if (ga) pa = 1'b0;
        end
        cyc(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ga, gm);
        // x0 load
        cyc(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd30, ga, gm);
        cyc(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ga, gm);
        // build streak 3, hold 3 cycles, then reset and check MEM wins
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'd11, 32'd111, 1, 5'(12 + i), 32'(200 + i), ga, gm);
        repeat (3) cyc(0, 1, 1, 5'd11, 32'd111, 1, 5'd20, 32'd300, ga, gm);
        cyc(1, 0, 1, 5'd11, 32'd111, 1, 5'd20, 32'd300, ga, gm);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 5'd11, 32'd111, 1, 5'(20 + i), 32'(300 + i), ga, gm);

        // randomised traffic honouring the hold-until-accepted rule
        pa = 1'b0; pm = 1'b0; ra = '0; rm = '0; rda = '0; rdm = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1'b1;
                ra = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                rda = $urandom;
            end
            if (!pm && $urandom_range(0, 2) != 0) begin
                pm = 1'b1;
                rm = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                rdm = $urandom;
            end
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
                pa, ra, rda, pm, rm, rdm, ga, gm);
            if (ga) pa = 1'b0;
            if (gm) pm = 1'b0;
        end

        cyc(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ga, gm);
        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected writes left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
